alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle MIPS ALU. It keeps the AND/OR/ADD/SUB/SLT operations and adds iterative unsigned multiply (MULTU) and divide (DIVU) producing a HI/LO pair. A valid/ready handshake on both sides lets the CPU datapath or a future multi-cycle controller stall on long operations.

---
 rtl/alu_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle MIPS-style ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT) finish one cycle after accept.
// MULTU (shift-add) and DIVU (restoring) iterate one bit per cycle for
// DATA_WIDTH cycles and produce a HI/LO pair.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   A, B, ALUop         operands and operation select, captured on accept
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   Result, ResultHi    LO/quotient and HI/remainder
//   Overflow, CarryOut, Zero, DivZero  registered status flags
module alu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic [DATA_WIDTH-1:0] ResultHi,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic                  DivZero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    // Multiplicand for MULTU, divisor for DIVU.
    logic [W-1:0]  opnd_q, opnd_d;
    // Working pair: {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  result_q, result_d;
    logic [W-1:0]  result_hi_q, result_hi_d;
    logic          ovf_q, ovf_d;
    logic          cout_q, cout_d;
    logic          zero_q, zero_d;
    logic          divz_q, divz_d;

    logic [W:0]    add_sum;
    logic [W:0]    sub_diff;
    logic [W-1:0]  single_res;
    logic          single_ovf;
    logic          single_cout;
    logic          single_zero;
    logic          op_known;

    logic [W:0]    mul_sum;
    logic [W:0]    div_rem_sh;
    logic [W-1:0]  div_trial;
    logic [W-1:0]  iter_hi;
    logic [W-1:0]  iter_lo;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Result    = result_q;
    assign ResultHi  = result_hi_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = cout_q;
    assign Zero      = zero_q;
    assign DivZero   = divz_q;

    // Single-cycle datapath, evaluated directly on the presented operands so the
    // result can be registered on the accept edge. The W+1-bit subtraction's top
    // bit is the unsigned borrow.
    always_comb begin
        add_sum     = {1'b0, A} + {1'b0, B};
        sub_diff    = {1'b0, A} - {1'b0, B};
        single_res  = '0;
        single_ovf  = 1'b0;
        single_cout = 1'b0;
        op_known    = 1'b1;
        case (ALUop)
            OP_AND: single_res = A & B;
            OP_OR:  single_res = A | B;
            OP_ADD: begin
                single_res  = add_sum[W-1:0];
                single_cout = add_sum[W];
                single_ovf  = (A[W-1] == B[W-1]) && (add_sum[W-1] != A[W-1]);
            end
            OP_SUB: begin
                single_res  = sub_diff[W-1:0];
                single_cout = sub_diff[W];
                single_ovf  = (A[W-1] != B[W-1]) && (sub_diff[W-1] != A[W-1]);
            end
            OP_SLT: single_res = ($signed(A) < $signed(B)) ? W'(1) : '0;
            default: op_known = 1'b0;
        endcase
        // Undefined opcodes report every flag low, including Zero.
        single_zero = op_known && (single_res == '0);
    end

    // One iteration of shift-add multiply or restoring divide. The shifted
    // remainder needs W+1 bits; after a successful subtract it fits in W again.
    // A zero divisor always "subtracts", which yields all-ones and rem = A.
    always_comb begin
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_rem_sh = {hi_q, lo_q[W-1]};
        div_trial  = div_rem_sh[W-1:0] - opnd_q;
        if (is_div_q) begin
            if (div_rem_sh >= {1'b0, opnd_q}) begin
                iter_hi = div_trial;
                iter_lo = {lo_q[W-2:0], 1'b1};
            end else begin
                iter_hi = div_rem_sh[W-1:0];
                iter_lo = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            iter_hi = mul_sum[W:1];
            iter_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    // Next-state logic for the control FSM and all datapath registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        ovf_d       = ovf_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        divz_d      = divz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    if (ALUop == OP_MULT) begin
                        is_div_d = 1'b0;
                        opnd_d   = A;
                        hi_d     = '0;
                        lo_d     = B;
                        state_d  = S_BUSY;
                    end else if (ALUop == OP_DIV) begin
                        is_div_d = 1'b1;
                        opnd_d   = B;
                        hi_d     = '0;
                        lo_d     = A;
                        state_d  = S_BUSY;
                    end else begin
                        result_d    = single_res;
                        result_hi_d = '0;
                        ovf_d       = single_ovf;
                        cout_d      = single_cout;
                        zero_d      = single_zero;
                        divz_d      = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                // The last iteration writes straight into the result registers;
                // the counter returns to 0 so it idles at its reset value.
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d       = '0;
                    result_d    = iter_lo;
                    result_hi_d = iter_hi;
                    ovf_d       = 1'b0;
                    cout_d      = 1'b0;
                    zero_d      = (iter_lo == '0);
                    divz_d      = is_div_q && (opnd_q == '0);
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            ovf_q       <= ovf_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            divz_q      <= divz_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq: a 32-bit and a 4-bit instance share one clock.
// Inputs are driven and outputs sampled on the falling edge.
module tb_alu_seq;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULT = 4'b1000;
   localparam logic [3:0] OP_DIV  = 4'b1001;

   logic clk;

   logic        rst32, inValid32, inReady32, outValid32, outReady32;
   logic [31:0] a32, b32, result32, resultHi32;
   logic [3:0]  op32;
   logic        ovf32, cout32, zero32, divz32;

   logic        rst4, inValid4, inReady4, outValid4, outReady4;
   logic [3:0]  a4, b4, result4, resultHi4;
   logic [3:0]  op4;
   logic        ovf4, cout4, zero4, divz4;

   int testsRun;
   int testsFailed;

   alu_seq #(.DATA_WIDTH(32)) dut32 (
      .clk(clk), .rst(rst32),
      .in_valid(inValid32), .in_ready(inReady32),
      .A(a32), .B(b32), .ALUop(op32),
      .out_valid(outValid32), .out_ready(outReady32),
      .Result(result32), .ResultHi(resultHi32),
      .Overflow(ovf32), .CarryOut(cout32), .Zero(zero32), .DivZero(divz32)
   );

   alu_seq #(.DATA_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4),
      .in_valid(inValid4), .in_ready(inReady4),
      .A(a4), .B(b4), .ALUop(op4),
      .out_valid(outValid4), .out_ready(outReady4),
      .Result(result4), .ResultHi(resultHi4),
      .Overflow(ovf4), .CarryOut(cout4), .Zero(zero4), .DivZero(divz4)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one operation for a single cycle; returns on the falling edge after accept.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      inValid32 = 1'b1;
      op32      = op;
      a32       = a;
      b32       = b;
      @(negedge clk);
      inValid32 = 1'b0;
   endtask

   task automatic applyStimulus4(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      inValid4 = 1'b1;
      op4      = op;
      a4       = a;
      b4       = b;
      @(negedge clk);
      inValid4 = 1'b0;
   endtask

   // Cycles since the accept edge until out_valid, bounded.
   task automatic waitValid32(output int cycles);
      cycles = 1;
      while (outValid32 !== 1'b1 && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic waitValid4(output int cycles);
      cycles = 1;
      while (outValid4 !== 1'b1 && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic release32();
      outReady32 = 1'b1;
      @(negedge clk);
      outReady32 = 1'b0;
   endtask

   task automatic release4();
      outReady4 = 1'b1;
      @(negedge clk);
      outReady4 = 1'b0;
   endtask

   // Directed sequence: each step has hand-computed expected values.
   initial begin
      int          cycles;
      logic        readyLow;
      logic        stable;
      logic [31:0] snapRes, snapHi;
      logic [3:0]  snapFlags;

      testsRun    = 0;
      testsFailed = 0;
      rst32 = 1'b1; inValid32 = 1'b0; outReady32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
      rst4  = 1'b1; inValid4  = 1'b0; outReady4  = 1'b0; a4  = '0; b4  = '0; op4  = '0;
      repeat (3) @(negedge clk);
      rst32 = 1'b0;
      rst4  = 1'b0;

      checkOutput("reset_ready_valid", {inReady32, outValid32}, 2'b10);
      checkOutput("reset_result", {resultHi32, result32}, 64'h0);
      checkOutput("reset_flags", {ovf32, cout32, zero32, divz32}, 4'b0000);
      checkOutput("reset4_state", {inReady4, outValid4, result4, resultHi4}, 10'b10_0000_0000);

      // ADD with signed overflow
      applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      checkOutput("add_ovf_latency", outValid32, 1'b1);
      checkOutput("add_ovf_result", result32, 32'h8000_0000);
      checkOutput("add_ovf_flags", {ovf32, cout32, zero32, divz32}, 4'b1000);
      release32();

      // ADD with unsigned carry wrapping to zero
      applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
      checkOutput("add_carry_result", result32, 32'h0);
      checkOutput("add_carry_flags", {ovf32, cout32, zero32, divz32}, 4'b0110);
      release32();

      applyStimulus(OP_SUB, 32'd5, 32'd5);
      checkOutput("sub_eq_result", result32, 32'h0);
      checkOutput("sub_eq_flags", {ovf32, cout32, zero32, divz32}, 4'b0010);
      release32();

      applyStimulus(OP_SUB, 32'd3, 32'd5);
      checkOutput("sub_borrow_result", result32, 32'hFFFF_FFFE);
      checkOutput("sub_borrow_flags", {ovf32, cout32, zero32, divz32}, 4'b0100);
      release32();

      applyStimulus(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      checkOutput("and_result", {resultHi32, result32}, 64'h0000_0000_00F0_00F0);
      release32();

      applyStimulus(OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      checkOutput("or_result", result32, 32'hFFF0_FFF0);
      release32();

      // MULTU: also drive junk while busy, which must be ignored and not queued.
      applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cycles   = 1;
      readyLow = 1'b1;
      a32 = '0; b32 = '0; op32 = OP_ADD; inValid32 = 1'b1;
      while (outValid32 !== 1'b1 && cycles < 200) begin
         if (inReady32 !== 1'b0) readyLow = 1'b0;
         if (cycles == 5) inValid32 = 1'b0;
         @(negedge clk);
         cycles++;
      end
      inValid32 = 1'b0;
      if (inReady32 !== 1'b0) readyLow = 1'b0;
      checkOutput("mult_latency", cycles, 33);
      checkOutput("mult_ready_low", readyLow, 1'b1);
      checkOutput("mult_lo", result32, 32'h0000_0001);
      checkOutput("mult_hi", resultHi32, 32'hFFFF_FFFE);
      checkOutput("mult_flags", {ovf32, cout32, zero32, divz32}, 4'b0000);
      release32();
      checkOutput("mult_no_queue", {inReady32, outValid32}, 2'b10);

      applyStimulus(OP_DIV, 32'd100, 32'd7);
      waitValid32(cycles);
      checkOutput("div32_latency", cycles, 33);
      checkOutput("div32_result", {resultHi32, result32}, {32'd2, 32'd14});
      release32();

      // SLT with held back-pressure
      applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
      checkOutput("slt_result", result32, 32'd1);
      snapRes   = result32;
      snapHi    = resultHi32;
      snapFlags = {ovf32, cout32, zero32, divz32};
      stable    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (outValid32 !== 1'b1 || inReady32 !== 1'b0 || result32 !== snapRes ||
             resultHi32 !== snapHi || {ovf32, cout32, zero32, divz32} !== snapFlags)
            stable = 1'b0;
      end
      checkOutput("slt_hold_stable", stable, 1'b1);
      release32();
      checkOutput("slt_release", {inReady32, outValid32}, 2'b10);

      // 4-bit divide and multiply
      applyStimulus4(OP_DIV, 4'd13, 4'd3);
      waitValid4(cycles);
      checkOutput("div4_latency", cycles, 5);
      checkOutput("div4_result", {resultHi4, result4}, {4'd1, 4'd4});
      checkOutput("div4_flags", {ovf4, cout4, zero4, divz4}, 4'b0000);
      release4();

      applyStimulus4(OP_DIV, 4'd9, 4'd0);
      waitValid4(cycles);
      checkOutput("div4_zero_latency", cycles, 5);
      checkOutput("div4_zero_result", {resultHi4, result4}, {4'd9, 4'hF});
      checkOutput("div4_zero_flags", {ovf4, cout4, zero4, divz4}, 4'b0001);
      release4();

      applyStimulus4(OP_DIV, 4'd2, 4'd7);
      waitValid4(cycles);
      checkOutput("div4_small_result", {resultHi4, result4}, {4'd2, 4'd0});
      checkOutput("div4_small_flags", {ovf4, cout4, zero4, divz4}, 4'b0010);
      release4();

      applyStimulus4(OP_MULT, 4'hF, 4'hF);
      waitValid4(cycles);
      checkOutput("mult4_latency", cycles, 5);
      checkOutput("mult4_result", {resultHi4, result4}, 8'hE1);
      release4();

      // Reset abort in the middle of a multiply
      applyStimulus(OP_MULT, 32'd3, 32'd5);
      repeat (6) @(negedge clk);
      rst32 = 1'b1;
      @(negedge clk);
      rst32 = 1'b0;
      checkOutput("abort_state", {inReady32, outValid32}, 2'b10);
      checkOutput("abort_result", {resultHi32, result32}, 64'h0);
      applyStimulus(OP_ADD, 32'd2, 32'd2);
      checkOutput("abort_add_valid", outValid32, 1'b1);
      checkOutput("abort_add_result", result32, 32'd4);
      release32();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
